// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT bit-reversed to natural-order reorder buffer.
package fft_reorder_pkg;

    localparam int FFT_N     = 4;
    localparam int FFT_W     = 16;
    localparam int FRAME_LEN = 1 << FFT_N;

    typedef enum logic {WR_IDLE, WR_FILL} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RUN}  rd_state_t;

    // Reverses the low n bits of value; bits at and above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[i] = value[n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one write port and one registered read port, each with its own bank select.
module fft_pingpong_ram
    import fft_reorder_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_bank,
    input  logic [N-1:0] wr_addr,
    input  logic [W-1:0] wr_re,
    input  logic [W-1:0] wr_im,
    input  logic         rd_en,
    input  logic         rd_bank,
    input  logic [N-1:0] rd_addr,
    output logic [W-1:0] rd_re,
    output logic [W-1:0] rd_im
);

    logic [2*W-1:0] mem [0:(2<<N)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= {wr_re, wr_im};
        end
    end

    // Only the read register is reset, so the array itself can map onto block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_re <= '0;
            rd_im <= '0;
        end else if (rd_en) begin
            {rd_re, rd_im} <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output stream in, natural bin order out.
// Define REORDER_FFTSHIFT_EN to emit each frame in fftshift order instead.
module fft_bitrev_reorder
    import fft_reorder_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    output logic         out_sof,
    output logic [N-1:0] out_idx,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         sof_err
);

    localparam logic [N-1:0] LAST = '1;
`ifdef REORDER_FFTSHIFT_EN
    localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
`endif

    wr_state_t    wr_state;
    logic [N-1:0] wr_cnt;
    logic         wbank;
    rd_state_t    rd_state;
    logic [N-1:0] rd_cnt;
    logic         rbank;
    logic [1:0]   bank_full;

    logic         wr_en;
    logic         wr_done;
    logic         wr_sel;
    logic [N-1:0] wr_addr;
    logic         rd_issue;
    logic         rd_done;
    logic [N-1:0] rd_addr;

    // A start-of-frame sample always lands at address 0; when it coincides with
    // the last write of a bank it belongs to the freshly selected bank.
    always_comb begin
        wr_en    = in_valid && (wr_state == WR_FILL || in_sof);
        wr_done  = in_valid && wr_state == WR_FILL && wr_cnt == LAST;
        wr_sel   = (wr_done && in_sof) ? ~wbank : wbank;
        wr_addr  = (in_sof || wr_state == WR_IDLE) ? '0 : N'(bitrev(32'(wr_cnt), N));
        rd_issue = bank_full[rbank];
        rd_done  = rd_issue && rd_cnt == LAST;
`ifdef REORDER_FFTSHIFT_EN
        rd_addr  = rd_cnt ^ HALF;
`else
        rd_addr  = rd_cnt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_cnt   <= '0;
            wbank    <= 1'b0;
            sof_err  <= 1'b0;
        end else begin
            sof_err <= 1'b0;
            if (in_valid) begin
                case (wr_state)
                    WR_IDLE: begin
                        if (in_sof) begin
                            wr_cnt   <= N'(1);
                            wr_state <= WR_FILL;
                        end
                    end
                    WR_FILL: begin
                        if (wr_cnt == LAST) begin
                            wbank <= ~wbank;
                            if (in_sof) begin
                                wr_cnt <= N'(1);
                            end else begin
                                wr_cnt   <= '0;
                                wr_state <= WR_IDLE;
                            end
                        end else if (in_sof) begin
                            sof_err <= 1'b1;
                            wr_cnt  <= N'(1);
                        end else begin
                            wr_cnt <= wr_cnt + N'(1);
                        end
                    end
                    default: wr_state <= WR_IDLE;
                endcase
            end
        end
    end

    // A bank becomes readable when its last sample is written and is handed back
    // after its last read; the two banks never complete and release together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= '0;
        end else begin
            if (wr_done) begin
                bank_full[wbank] <= 1'b1;
            end
            if (rd_done) begin
                bank_full[rbank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= RD_IDLE;
            rd_cnt    <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= rd_issue;
            out_sof   <= rd_issue && rd_cnt == '0;
            if (rd_issue) begin
                out_idx <= rd_addr;
                if (rd_done) begin
                    rd_cnt   <= '0;
                    rbank    <= ~rbank;
                    rd_state <= bank_full[~rbank] ? RD_RUN : RD_IDLE;
                end else begin
                    rd_cnt   <= rd_cnt + N'(1);
                    rd_state <= RD_RUN;
                end
            end else begin
                rd_state <= RD_IDLE;
            end
        end
    end

    fft_pingpong_ram #(.N(N), .W(W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_bank (wr_sel),
        .wr_addr (wr_addr),
        .wr_re   (in_re),
        .wr_im   (in_im),
        .rd_en   (rd_issue),
        .rd_bank (rbank),
        .rd_addr (rd_addr),
        .rd_re   (out_re),
        .rd_im   (out_im)
    );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=4, W=16); honours REORDER_FFTSHIFT_EN when defined.
module tb_fft_bitrev_reorder;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_sof;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         out_valid;
    logic         out_sof;
    logic [N-1:0] out_idx;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         sof_err;

    int cyc       = 0;
    int cmpCnt    = 0;
    int failCnt   = 0;
    int errPulses = 0;

    logic [W-1:0] qRe  [$];
    logic [W-1:0] qIm  [$];
    logic [N-1:0] qIdx [$];
    logic         qSof [$];
    int           qCyc [$];

    fft_bitrev_reorder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_idx   (out_idx),
        .out_re    (out_re),
        .out_im    (out_im),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output capture plus the overflow guard: a write must never target a full bank.
    always @(negedge clk) begin
        if (out_valid) begin
            qRe.push_back(out_re);
            qIm.push_back(out_im);
            qIdx.push_back(out_idx);
            qSof.push_back(out_sof);
            qCyc.push_back(cyc);
        end
        if (sof_err) errPulses++;
        if (!rst && dut.wr_en && dut.bank_full[dut.wr_sel]) begin
            failCnt++;
            $display("[TB] FAIL full_bank_write: observed write into full bank %0d, required none", dut.wr_sel);
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] tbRev(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Bin index expected at output position k of a frame.
    function automatic logic [3:0] natIdx(input int k);
        logic [3:0] b;
        b = 4'(k);
`ifdef REORDER_FFTSHIFT_EN
        b[3] = ~b[3];
`endif
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic sof, input logic [W-1:0] re, input logic [W-1:0] im);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = sof;
        in_re    = re;
        in_im    = im;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic clearQ();
        qRe.delete();
        qIm.delete();
        qIdx.delete();
        qSof.delete();
        qCyc.delete();
    endtask

    // mode 0: re = raw position p; mode 1: re = bitrev4(p). im is always -re.
    task automatic sendFrame(input int mode, input bit gaps, output int sofCyc, output int lastCyc);
        logic [W-1:0] val;
        for (int p = 0; p < 16; p++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) applyStimulus(1'b0, 1'b0, '0, '0);
            end
            val = (mode == 1) ? 16'(tbRev(4'(p))) : 16'(p);
            applyStimulus(1'b1, p == 0, val, -val);
            if (p == 0) sofCyc = cyc;
            lastCyc = cyc;
        end
    endtask

    task automatic checkFrame(input string tag, input int base, input int mode, input int firstCyc);
        logic [W-1:0] expRe;
        logic [W-1:0] expIm;
        for (int k = 0; k < 16 && base + k < qRe.size(); k++) begin
            expRe = (mode == 1) ? 16'(natIdx(k)) : 16'(tbRev(natIdx(k)));
            expIm = -expRe;
            checkOutput($sformatf("%s_re%0d", tag, k), 32'(qRe[base+k]), 32'(expRe));
            checkOutput($sformatf("%s_im%0d", tag, k), 32'(qIm[base+k]), 32'(expIm));
            checkOutput($sformatf("%s_idx%0d", tag, k), 32'(qIdx[base+k]), 32'(natIdx(k)));
            checkOutput($sformatf("%s_sof%0d", tag, k), 32'(qSof[base+k]), 32'(k == 0));
            checkOutput($sformatf("%s_cyc%0d", tag, k), 32'(qCyc[base+k]), 32'(firstCyc + k));
        end
    endtask

    task automatic checkOutputsZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(0));
        checkOutput({tag, "_sof"}, 32'(out_sof), 32'(0));
        checkOutput({tag, "_idx"}, 32'(out_idx), 32'(0));
        checkOutput({tag, "_re"}, 32'(out_re), 32'(0));
        checkOutput({tag, "_im"}, 32'(out_im), 32'(0));
        checkOutput({tag, "_err"}, 32'(sof_err), 32'(0));
    endtask

    initial begin
        int s1, l1, s2, l2, s3, l3;
        int errBase;
        bit found;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        #12;
        checkOutputsZero("reset");
        @(negedge clk);
        rst = 1'b0;
        idleCycles(3);

        $display("[TB] test 1: single frame, raw positions");
        clearQ();
        sendFrame(0, 1'b0, s1, l1);
        idleCycles(24);
        checkOutput("t1_count", 32'(qRe.size()), 32'(16));
        checkFrame("t1", 0, 0, s1 + 17);

        $display("[TB] test 2: three back-to-back frames, bit-reversed data");
        clearQ();
        sendFrame(1, 1'b0, s1, l1);
        sendFrame(1, 1'b0, s2, l2);
        sendFrame(1, 1'b0, s3, l3);
        idleCycles(24);
        checkOutput("t2_count", 32'(qRe.size()), 32'(48));
        checkFrame("t2a", 0, 1, s1 + 17);
        checkFrame("t2b", 16, 1, s2 + 17);
        checkFrame("t2c", 32, 1, s3 + 17);

        $display("[TB] test 3: frame with random input gaps");
        clearQ();
        sendFrame(0, 1'b1, s1, l1);
        idleCycles(24);
        checkOutput("t3_count", 32'(qRe.size()), 32'(16));
        checkFrame("t3", 0, 0, l1 + 2);

        $display("[TB] test 4: early in_sof aborts a partial frame");
        clearQ();
        errBase = errPulses;
        for (int p = 0; p < 7; p++) applyStimulus(1'b1, p == 0, 16'(100 + p), 16'(200 + p));
        sendFrame(0, 1'b0, s1, l1);
        idleCycles(24);
        checkOutput("t4_sof_err", 32'(errPulses - errBase), 32'(1));
        checkOutput("t4_count", 32'(qRe.size()), 32'(16));
        checkFrame("t4", 0, 0, s1 + 17);

        $display("[TB] test 5: reset during output, then sof-less input");
        clearQ();
        sendFrame(0, 1'b0, s1, l1);
        idleCycles(1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_idx == natIdx(5)) found = 1'b1;
        end
        checkOutput("t5_reached_sample5", 32'(found), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutputsZero("t5_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearQ();
        for (int p = 0; p < 16; p++) applyStimulus(1'b1, 1'b0, 16'(p), 16'(p));
        idleCycles(30);
        checkOutput("t5_no_output", 32'(qRe.size()), 32'(0));
        sendFrame(0, 1'b0, s1, l1);
        idleCycles(24);
        checkOutput("t5_count", 32'(qRe.size()), 32'(16));
        checkFrame("t5", 0, 0, s1 + 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side consumer of the radix-2 SDF FFT stream. Accepts one complex sample per cycle in bit-reversed bin order and re-emits each frame in natural bin order.
- Uses a ping-pong buffer of two banks, each 2^N entries. One bank is written while the other is read.
- Sits directly after the fft core. It replaces simulation-only reshuffling with synthesizable fixed-point hardware.

Parameters:
- N, 4, log2 of FFT points; frame length is 2^N.
- W, 16, two's-complement width of each real/imag component.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample present this cycle
- in_sof  in  1  first sample of a frame; only meaningful when in_valid=1
- in_re  in  W  real part, bit-reversed order
- in_im  in  W  imag part, bit-reversed order
- out_valid  out  1  output sample valid
- out_sof  out  1  high with bin 0 of each output frame
- out_idx  out  N  natural bin index of the output sample
- out_re  out  W  real part, natural order
- out_im  out  W  imag part, natural order
- sof_err  out  1  one-cycle pulse when a frame is aborted by an early in_sof

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0.
  - Both FSMs go to IDLE and all counters clear.
  - Bank contents are don't-care. No output is produced from pre-reset data.
- Write FSM, states WR_IDLE and WR_FILL:
  - WR_IDLE: in_valid without in_sof is discarded. in_valid & in_sof writes the sample at wr_cnt=0, sets wr_cnt=1 and enters WR_FILL.
  - WR_FILL: each in_valid writes mem[wbank][bitrev_N(wr_cnt)] and increments wr_cnt. in_valid=0 holds all state, so gaps are allowed.
  - Writing at wr_cnt=2^N-1 completes the bank:
    - Marks wbank full, toggles wbank, returns to WR_IDLE.
    - If in_sof arrives in the same cycle, that sample instead starts the next frame in the new bank.
  - in_sof while in WR_FILL with wr_cnt≠0 aborts the partial frame:
    - Pulse sof_err.
    - Restart at wr_cnt=0 with this sample, in the same bank.
- Read FSM, states RD_IDLE and RD_RUN:
  - Enters RD_RUN in the cycle after a bank is marked full, with rd_cnt=0.
  - Issues one read per cycle, with no gaps and no backpressure.
  - Output is registered, so out_* for rd_cnt=k appears one cycle after the read is issued.
  - After rd_cnt=2^N-1 the bank is released. If the other bank is already full, reading continues with no bubble (out_sof back-to-back); otherwise the FSM goes to RD_IDLE.
- Latency: the last input sample of a frame accepted at cycle t gives bin 0 at cycle t+2. With no input gaps, that is 2^N+1 cycles after the in_sof sample.
- Overflow cannot occur. Write needs at least 2^N cycles per frame and read needs exactly 2^N, so a bank is always released before it is re-filled. The bench asserts that a full bank is never written.
- out_idx equals rd_cnt, delayed one cycle. Data is passed unmodified with no width change.
- Reset mid-read: output stops in the next cycle and the partial frame is lost.

Optional Feature:
- Macro REORDER_FFTSHIFT_EN.
- Defined: the read address is rd_cnt XOR 2^(N-1), so the output runs in fftshift order (bins 2^(N-1)..2^N-1, then 0..2^(N-1)-1). out_idx reports the actual bin. out_sof still marks the first output of the frame.
- Undefined: natural order, 0..2^N-1.

Decomposition:
- Package fft_reorder_pkg holds:
  - FRAME_LEN = 1<<N.
  - Write and read state enums.
  - A bitrev function parameterised by N.
- Sub-module fft_pingpong_ram: two banks, one write port and one registered read port, with bank select bits. The parent holds both FSMs.

Test Plan:
- N=4, one frame with in_re=p, in_im=-p at raw position p=0..15, no gaps → out_re = bitrev4(idx), i.e. 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_idx runs 0..15, out_sof only with idx 0, and the first output lands 17 cycles after in_sof.
- Input in_re=bitrev4(p) → out_re=0..15 monotonically. Three back-to-back frames give 48 consecutive out_valid cycles and out_sof every 16 cycles.
- Random in_valid gaps (~50% duty) within a frame → output identical to the gap-free case. Output is contiguous 16 cycles starting 2 cycles after the 16th accepted sample.
- in_sof at p=7 of a frame, then a full frame → sof_err pulses once, and only the second frame is output.
- Assert rst during output sample 5 → all outputs become 0 asynchronously. After release, samples with in_valid=1 but no in_sof produce no output until the next in_sof.
- With REORDER_FFTSHIFT_EN defined, input in_re=bitrev4(p) → out_re = 8..15, 0..7, and out_idx matches out_re.
